uart_tx_frame: RTL and testbench

//  Serial UART transmitter driven by an externally generated 1-clk baud pulse (baud_clk.baud_trig_tx).

---
 rtl/uart_tx_frame.sv | 141 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter paced by an external one-clock baud pulse.
// Sends start bit, DATA_BITS data bits LSB first, an optional parity bit,
// then STOP_BITS stop bits. The line output is registered, so each bit
// starts on the clock edge that samples baud_trig and lasts one baud period.
module uart_tx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_trig,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int               CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);
    localparam logic             PAR_EN    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_q,    tx_d;
    logic                 busy_q;
    logic                 done_q,  done_d;

    // Next-state logic: frame sequencing, shift/count updates and line level.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // baud_trig is deliberately ignored here; ARM re-aligns to the grid.
                if (tx_valid) begin
                    state_d  = S_ARM;
                    shreg_d  = tx_data;
                    parity_d = (^tx_data) ^ PAR_ODD;
                    cnt_d    = '0;
                end
            end
            S_ARM: begin
                if (baud_trig) state_d = S_START;
            end
            S_START: begin
                if (baud_trig) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_trig) begin
                    shreg_d = shreg_q >> 1;
                    if (cnt_q == LAST_DATA) begin
                        cnt_d   = '0;
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_trig) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
            S_STOP: begin
                if (baud_trig) begin
                    if (cnt_q == LAST_STOP) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Line level follows the state being entered, so it changes on the trigger edge.
        unique case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
            S_PARITY: tx_d = parity_q;
            default:  tx_d = 1'b1;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: the shift register and counter are cleared too, so an aborted frame leaves no stale data behind.
        if (!rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the same pre-edge values.
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= (state_d != S_IDLE);
            done_q   <= done_d;
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign tx       = tx_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: three transmitter configurations (8N1, 8E2, 8O1) on a
// shared clock, reset and baud pulse. Each frame is predicted as a list of
// line levels and compared clock by clock against the serial output.
module tb_uart_tx_frame;

    localparam int BAUD = 16;
    localparam int NI   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_trig;
    logic       tx_valid [NI];
    logic [7:0] tx_data  [NI];
    logic       tx_ready [NI];
    logic       tx       [NI];
    logic       tx_busy  [NI];
    logic       tx_done  [NI];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int baud_cnt = 0;
    bit cont_mode = 1'b0;
    bit edge_trig;
    int run_hi  [NI];
    int last_hi [NI];
    bit exp_bits [16];
    int exp_n;

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_8n1 (
        .clk(clk), .rst(rst), .baud_trig(baud_trig),
        .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .tx_ready(tx_ready[0]),
        .tx(tx[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0])
    );

    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut_8e2 (
        .clk(clk), .rst(rst), .baud_trig(baud_trig),
        .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .tx_ready(tx_ready[1]),
        .tx(tx[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1])
    );

    uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_8o1 (
        .clk(clk), .rst(rst), .baud_trig(baud_trig),
        .tx_valid(tx_valid[2]), .tx_data(tx_data[2]), .tx_ready(tx_ready[2]),
        .tx(tx[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: remember the trigger the coming edge sees, advance to the
    // following negedge, track high runs on each line, schedule the next trigger.
    task automatic step();
        edge_trig = baud_trig;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (tx[i] === 1'b1) run_hi[i]++;
            else begin
                if (run_hi[i] > 0) last_hi[i] = run_hi[i];
                run_hi[i] = 0;
            end
        end
        if (cont_mode) baud_trig = 1'b1;
        else begin
            baud_cnt  = (baud_cnt + 1) % BAUD;
            baud_trig = (baud_cnt == 0);
        end
        if (cyc > 60000) begin
            $display("FAIL cycle_budget observed=%0d expected<=60000", cyc);
            $fatal(1);
        end
    endtask

    // Expected line levels for a word on instance k, from the frame format.
    function automatic void build_frame(input int k, input logic [7:0] w);
        int ones;
        int pen;
        int odd;
        int stops;
        pen   = (k == 0) ? 0 : 1;
        odd   = (k == 2) ? 1 : 0;
        stops = (k == 1) ? 2 : 1;
        ones  = 0;
        exp_n = 0;
        exp_bits[exp_n] = 1'b0;
        exp_n = exp_n + 1;
        for (int i = 0; i < 8; i++) begin
            exp_bits[exp_n] = w[i];
            exp_n = exp_n + 1;
            ones  = ones + int'(w[i]);
        end
        if (pen == 1) begin
            exp_bits[exp_n] = (odd == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            exp_n = exp_n + 1;
        end
        for (int s = 0; s < stops; s++) begin
            exp_bits[exp_n] = 1'b1;
            exp_n = exp_n + 1;
        end
    endfunction

    // hold: 0 drop valid after accept, 1 hold through frame, 2 leave high afterwards.
    // abort_seen >= 0 pulses reset mid-bit once that many triggers have passed.
    task automatic send(input int k, input logic [7:0] w, input int hold, input bit scramble,
                        input bit coincide, input int abort_seen, output int gap);
        int  seen;
        int  guard;
        int  c;
        int  bit_clk;
        bit  done_f;
        bit  abort_f;
        logic exp_tx;
        gap     = 0;
        done_f  = 1'b0;
        abort_f = 1'b0;
        build_frame(k, w);
        guard = 0;
        while (tx_ready[k] !== 1'b1 && guard < 400) begin
            step();
            guard++;
        end
        check("ready_before_accept", 32'(tx_ready[k]), 1);
        if (coincide) begin
            guard = 0;
            while (baud_trig !== 1'b1 && guard <= BAUD) begin
                step();
                guard++;
            end
            check("coincident_trigger", 32'(baud_trig), 1);
        end
        tx_valid[k] = 1'b1;
        tx_data[k]  = w;
        step();
        if (hold == 0) tx_valid[k] = 1'b0;
        if (scramble) tx_data[k] = ~w;
        seen    = 0;
        bit_clk = 0;
        c       = 0;
        while (!done_f && !abort_f && c < (exp_n + 3) * BAUD) begin
            if (c > 0) begin
                step();
                if (edge_trig) begin
                    seen++;
                    bit_clk = 0;
                end else begin
                    bit_clk++;
                end
            end
            if (seen <= exp_n) begin
                exp_tx = (seen == 0) ? 1'b1 : exp_bits[seen-1];
                check($sformatf("tx_i%0d_bit%0d", k, seen), 32'(tx[k]), 32'(exp_tx));
                check("busy_in_frame", 32'(tx_busy[k]), 1);
                check("ready_in_frame", 32'(tx_ready[k]), 0);
                check("done_in_frame", 32'(tx_done[k]), 0);
            end else begin
                check("tx_at_done", 32'(tx[k]), 1);
                check("busy_at_done", 32'(tx_busy[k]), 0);
                check("ready_at_done", 32'(tx_ready[k]), 1);
                check("done_pulse", 32'(tx_done[k]), 1);
                done_f = 1'b1;
            end
            if (seen == 1 && gap == 0) gap = last_hi[k];
            if (abort_seen >= 0 && seen == abort_seen && bit_clk == 5) begin
                rst = 1'b0;
                step();
                rst = 1'b1;
                check("abort_tx", 32'(tx[k]), 1);
                check("abort_busy", 32'(tx_busy[k]), 0);
                check("abort_ready", 32'(tx_ready[k]), 1);
                check("abort_done", 32'(tx_done[k]), 0);
                step();
                check("abort_done_after", 32'(tx_done[k]), 0);
                check("abort_tx_after", 32'(tx[k]), 1);
                abort_f = 1'b1;
            end
            c++;
        end
        if (abort_seen < 0) check("frame_completed", 32'(done_f), 1);
        if (hold == 1) tx_valid[k] = 1'b0;
    endtask

    initial begin
        int          gap;
        logic [7:0]  w;
        rst       = 1'b0;
        baud_trig = 1'b0;
        for (int i = 0; i < NI; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = 8'h00;
            run_hi[i]   = 0;
            last_hi[i]  = 0;
        end
        step();
        step();
        for (int i = 0; i < NI; i++) begin
            check("rst_tx", 32'(tx[i]), 1);
            check("rst_busy", 32'(tx_busy[i]), 0);
            check("rst_done", 32'(tx_done[i]), 0);
            check("rst_ready", 32'(tx_ready[i]), 1);
        end
        rst = 1'b1;
        step();

        // 8N1, 0xA5: expected levels 0,1,0,1,0,0,1,0,1,1 at 16 clk each.
        send(0, 8'hA5, 0, 1'b0, 1'b0, -1, gap);
        step();
        check("idle_busy_after_a5", 32'(tx_busy[0]), 0);
        check("idle_done_after_a5", 32'(tx_done[0]), 0);

        // Parity: 0x07 even -> 1, odd -> 0.
        send(1, 8'h07, 0, 1'b0, 1'b0, -1, gap);
        send(2, 8'h07, 0, 1'b0, 1'b0, -1, gap);

        // Two stop bits, back-to-back with valid held high.
        send(1, 8'h00, 2, 1'b0, 1'b0, -1, gap);
        send(1, 8'hFF, 1, 1'b0, 1'b0, -1, gap);
        check("b2b_gap_min32", 32'(gap >= 32), 1);
        check("b2b_gap_max48", 32'(gap <= 48), 1);

        // Valid held and data scrambled mid-frame.
        send(0, 8'h3A, 1, 1'b1, 1'b0, -1, gap);

        // Accept on a trigger clock; that trigger must not start the frame.
        send(0, 8'h5A, 0, 1'b0, 1'b1, -1, gap);

        // Reset during data bit 3, then a clean 0x3C frame.
        send(0, 8'hC3, 0, 1'b0, 1'b0, 5, gap);
        send(0, 8'h3C, 0, 1'b0, 1'b0, -1, gap);

        // Randomised frames across all three configurations.
        for (int n = 0; n < 12; n++) begin
            w = 8'($urandom);
            send(int'($urandom_range(0, NI - 1)), w, int'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, gap);
        end

        // Trigger held high continuously: one bit per clock.
        cont_mode = 1'b1;
        baud_trig = 1'b1;
        w = 8'($urandom);
        send(1, w, 0, 1'b0, 1'b0, -1, gap);
        w = 8'($urandom);
        send(2, w, 0, 1'b0, 1'b0, -1, gap);
        cont_mode = 1'b0;
        baud_trig = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
